// File: rtl/ci_cmd_framer_if.sv
// UART-side byte interface of the CI command framer.
// master: the UART receiver/transmitter pair; slave: the framer.
interface ci_cmd_framer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;

  modport master (
    output rx_valid, rx_data, rx_break, tx_busy,
    input  tx_en, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, rx_break, tx_busy,
    output tx_en, tx_data
  );
endinterface

// File: rtl/ci_cmd_framer.sv
// Framed command parser: validates {A5, OPC, ARG, CHK} frames from the UART,
// drives SoC clock gate / reset / tx-rx muxing, and answers each completed
// frame with a single ACK, NAK or status byte.
module ci_cmd_framer #(
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 10,
  parameter int unsigned RESET_SCALE    = 16
) (
  input  logic           clk,
  input  logic           resetn,
  ci_cmd_framer_if.slave bus,
  output logic           soc_clk_en,
  output logic           soc_reset,
  output logic           tx_sel,
  output logic           rx_gate,
  output logic           frame_err
);

  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PW   = $clog2(256 * RESET_SCALE + 1);
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_ARG, S_CHK, S_RESP} state_t;

  state_t        state, state_n;
  logic [7:0]    opc, opc_n;
  logic [7:0]    arg, arg_n;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] pulse_cnt, pulse_n;
  logic          clk_en_n, sel_n, gate_n, err_n, tx_en_n;
  logic [7:0]    tx_data_n;
  logic          in_frame, tmo_hit;

  assign in_frame = (state == S_OPC) || (state == S_ARG) || (state == S_CHK);
  // The idle counter would reach TIMEOUT_CYCLES on this edge.
  assign tmo_hit  = in_frame && !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state, frame execution and next output values.
  always_comb begin
    state_n   = state;
    opc_n     = opc;
    arg_n     = arg;
    clk_en_n  = soc_clk_en;
    sel_n     = tx_sel;
    gate_n    = rx_gate;
    pulse_n   = (pulse_cnt != '0) ? pulse_cnt - 1'b1 : '0;
    err_n     = 1'b0;
    tx_en_n   = 1'b0;
    tx_data_n = bus.tx_data;
    case (state)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC)) state_n = S_OPC;
      end
      S_OPC, S_ARG, S_CHK: begin
        if (bus.rx_break || tmo_hit) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else if (bus.rx_valid) begin
          if (state == S_OPC) begin
            opc_n   = bus.rx_data;
            state_n = S_ARG;
          end else if (state == S_ARG) begin
            arg_n   = bus.rx_data;
            state_n = S_CHK;
          end else begin
            state_n = S_RESP;
            if ((bus.rx_data == (opc ^ arg ^ SYNC)) && (opc <= 8'h08)) begin
              case (opc[3:0])
                4'h0: clk_en_n = 1'b0;
                4'h1: clk_en_n = 1'b1;
                4'h2: pulse_n  = PW'({1'b0, arg} + 9'd1) * PW'(RESET_SCALE);
                4'h3: pulse_n  = '0;
                4'h4: sel_n    = 1'b0;
                4'h5: sel_n    = 1'b1;
                4'h6: gate_n   = 1'b0;
                4'h7: gate_n   = 1'b1;
                default: ;
              endcase
              // Status reflects the control values as they stand after this edge.
              tx_data_n = (opc == 8'h08) ?
                          {1'b1, 3'b000, (pulse_n != '0), gate_n, sel_n, clk_en_n} : ACK;
            end else begin
              tx_data_n = NAK;
              err_n     = 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        if (!bus.tx_busy) begin
          tx_en_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered datapath and outputs; no input reaches an output combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opc         <= '0;
      arg         <= '0;
      tmo_cnt     <= '0;
      pulse_cnt   <= '0;
      soc_clk_en  <= 1'b1;
      soc_reset   <= 1'b0;
      tx_sel      <= 1'b0;
      rx_gate     <= 1'b0;
      frame_err   <= 1'b0;
      bus.tx_en   <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      opc         <= opc_n;
      arg         <= arg_n;
      tmo_cnt     <= (in_frame && !bus.rx_valid && (state_n == state)) ? tmo_cnt + 1'b1 : '0;
      pulse_cnt   <= pulse_n;
      soc_clk_en  <= clk_en_n;
      soc_reset   <= (pulse_n != '0);
      tx_sel      <= sel_n;
      rx_gate     <= gate_n;
      frame_err   <= err_n;
      bus.tx_en   <= tx_en_n;
      bus.tx_data <= tx_data_n;
    end
  end

endmodule

// File: tb/tb_ci_cmd_framer.sv
// Self-checking bench for ci_cmd_framer: table of directed frames, hand-written
// corner sequences, and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_ci_cmd_framer;
  localparam int unsigned T_OUT = 300;
  localparam int unsigned RS    = 16;

  logic clk = 1'b0;
  logic resetn;
  logic soc_clk_en, soc_reset, tx_sel, rx_gate, frame_err;

  ci_cmd_framer_if bus();

  ci_cmd_framer #(.TIMEOUT_CYCLES(T_OUT), .RESET_SCALE(RS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .soc_clk_en (soc_clk_en),
    .soc_reset  (soc_reset),
    .tx_sel     (tx_sel),
    .rx_gate    (rx_gate),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        busy_at_edge = 1'b0;
  bit          mon_on = 1'b0;

  // Frame-level model: control levels plus the cycle at which the SoC reset ends.
  logic        m_clk, m_sel, m_gate;
  int unsigned m_rst_end;

  typedef struct { int unsigned c; logic [7:0] d; } txrec_t;
  txrec_t      txq[$];
  int unsigned errq[$];

  typedef struct {
    logic [7:0] opc, arg, chk;
    int unsigned hold;
    logic [7:0] resp;
    logic err, clk_en, sel, gate;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clk = 1'b1; m_sel = 1'b0; m_gate = 1'b0; m_rst_end = 0;
  endtask

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= bus.tx_busy;
  end

  always @(negedge clk) begin
    if (resetn && mon_on) begin
      check("mon_clk_en", soc_clk_en, m_clk);
      check("mon_tx_sel", tx_sel, m_sel);
      check("mon_rx_gate", rx_gate, m_gate);
      check("mon_soc_reset", soc_reset, cyc < m_rst_end);
      check("mon_tx_en_vs_busy", bus.tx_en & busy_at_edge, 0);
      if (bus.tx_en)  txq.push_back('{c: cyc, d: bus.tx_data});
      if (frame_err)  errq.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] opc, input logic [7:0] arg, input logic [7:0] chk,
                          input int unsigned hold, input bit inject,
                          output logic [7:0] resp_got, output int unsigned err_got);
    logic        good;
    logic [7:0]  exp;
    int unsigned ce;
    send_byte(8'hA5);
    send_byte(opc);
    send_byte(arg);
    txq.delete();
    errq.delete();
    send_byte(chk);
    bus.tx_busy = (hold > 0);
    ce   = cyc;
    good = (chk == (opc ^ arg ^ 8'hA5)) && (opc <= 8'h08);
    exp  = 8'h15;
    if (good) begin
      exp = 8'h06;
      case (opc)
        8'h00: m_clk = 1'b0;
        8'h01: m_clk = 1'b1;
        8'h02: m_rst_end = ce + (int'(arg) + 1) * RS;
        8'h03: m_rst_end = 0;
        8'h04: m_sel = 1'b0;
        8'h05: m_sel = 1'b1;
        8'h06: m_gate = 1'b0;
        8'h07: m_gate = 1'b1;
        8'h08: exp = {4'b1000, ce < m_rst_end, m_gate, m_sel, m_clk};
        default: ;
      endcase
    end
    if (hold > 0) begin
      if (inject) begin
        send_byte(8'hA5);
        repeat (hold - 2) @(posedge clk);
      end else begin
        repeat (hold) @(posedge clk);
      end
      #1 bus.tx_busy = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("resp_count", txq.size(), 1);
    if (txq.size() > 0) begin
      check("resp_cycle", txq[0].c, ce + hold + 1);
      check("resp_data", txq[0].d, exp);
      resp_got = txq[0].d;
    end else begin
      resp_got = 8'hxx;
    end
    check("err_count", errq.size(), good ? 0 : 1);
    if (errq.size() > 0) check("err_cycle", errq[0], ce);
    err_got = errq.size();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk_en"}, soc_clk_en, 1);
    check({tag, "_soc_reset"}, soc_reset, 0);
    check({tag, "_tx_sel"}, tx_sel, 0);
    check({tag, "_rx_gate"}, rx_gate, 0);
    check({tag, "_tx_en"}, bus.tx_en, 0);
    check({tag, "_tx_data"}, bus.tx_data, 8'h00);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rg, opc, arg, chk, nb;
    int unsigned eg, c0;

    tbl[0]  = '{8'h08, 8'h00, 8'hAD, 100, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'h05, 8'h00, 8'hA0,   0, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{8'h01, 8'h00, 8'h00,   0, 8'h15, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{8'h0A, 8'h00, 8'hAF,   0, 8'h15, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 8'h00, 8'hA5,   2, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8'h07, 8'h00, 8'hA2,   3, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{8'h08, 8'h00, 8'hAD,   0, 8'h86, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{8'h04, 8'h00, 8'hA1,   0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h06, 8'h00, 8'hA3,   1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h01, 8'h00, 8'hA4,   0, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'h08, 8'h00, 8'hAD,   0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0};

    resetn = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_break = 1'b0; bus.tx_busy = 1'b0;
    model_reset();
    #12;
    check_reset_values("por");
    @(posedge clk); #1 resetn = 1'b1; mon_on = 1'b1;
    repeat (2) @(posedge clk);

    // Directed frames with precomputed responses and resulting control levels.
    for (int i = 0; i < 11; i++) begin
      do_frame(tbl[i].opc, tbl[i].arg, tbl[i].chk, tbl[i].hold, 1'b0, rg, eg);
      check($sformatf("tbl%0d_resp", i), rg, tbl[i].resp);
      check($sformatf("tbl%0d_err", i), eg, tbl[i].err);
      check($sformatf("tbl%0d_clk_en", i), soc_clk_en, tbl[i].clk_en);
      check($sformatf("tbl%0d_tx_sel", i), tx_sel, tbl[i].sel);
      check($sformatf("tbl%0d_rx_gate", i), rx_gate, tbl[i].gate);
    end

    // 64-cycle reset pulse, restarted mid-pulse.
    do_frame(8'h02, 8'h03, 8'hA4, 0, 1'b0, rg, eg);
    repeat (20) @(posedge clk);
    do_frame(8'h02, 8'h03, 8'hA4, 0, 1'b0, rg, eg);
    repeat (55) @(posedge clk); #1;
    check("pulse_restart_high", soc_reset, 1);
    repeat (10) @(posedge clk); #1;
    check("pulse_restart_end", soc_reset, 0);

    // 03 cancels a running pulse; pulse runs with SoC clock stopped.
    do_frame(8'h02, 8'h10, 8'hB7, 0, 1'b0, rg, eg);
    repeat (10) @(posedge clk);
    do_frame(8'h03, 8'h00, 8'hA6, 0, 1'b0, rg, eg);
    check("pulse_cleared", soc_reset, 0);
    do_frame(8'h00, 8'h00, 8'hA5, 0, 1'b0, rg, eg);
    do_frame(8'h02, 8'h01, 8'hA6, 0, 1'b0, rg, eg);
    repeat (40) @(posedge clk);
    do_frame(8'h01, 8'h00, 8'hA4, 0, 1'b0, rg, eg);

    // A byte arriving while the response is pending is dropped.
    do_frame(8'h04, 8'h00, 8'hA1, 6, 1'b1, rg, eg);
    do_frame(8'h08, 8'h00, 8'hAD, 0, 1'b0, rg, eg);
    check("resp_drop_status", rg, 8'h81);

    // Noise in IDLE.
    txq.delete(); errq.delete();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    repeat (3) @(posedge clk); #1;
    check("noise_err", errq.size(), 0);
    check("noise_tx", txq.size(), 0);

    // BREAK mid-frame aborts; BREAK in IDLE is ignored.
    txq.delete(); errq.delete();
    send_byte(8'hA5);
    @(posedge clk); #1 bus.rx_break = 1'b1;
    @(posedge clk); #1 bus.rx_break = 1'b0; c0 = cyc;
    repeat (3) @(posedge clk); #1 bus.rx_break = 1'b1;
    @(posedge clk); #1 bus.rx_break = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("brk_err_count", errq.size(), 1);
    if (errq.size() > 0) check("brk_err_cycle", errq[0], c0);
    check("brk_tx", txq.size(), 0);
    do_frame(8'h05, 8'h00, 8'hA0, 0, 1'b0, rg, eg);

    // Inter-byte timeout.
    txq.delete(); errq.delete();
    send_byte(8'hA5); send_byte(8'h07); c0 = cyc;
    repeat (T_OUT + 5) @(posedge clk); #1;
    check("tmo_err_count", errq.size(), 1);
    if (errq.size() > 0) check("tmo_err_cycle", errq[0], c0 + T_OUT);
    check("tmo_tx", txq.size(), 0);
    check("tmo_gate_unchanged", rx_gate, 0);
    do_frame(8'h07, 8'h00, 8'hA2, 0, 1'b0, rg, eg);
    check("tmo_next_frame", rg, 8'h06);

    // resetn mid-frame and mid-pulse.
    do_frame(8'h02, 8'h09, 8'hAE, 0, 1'b0, rg, eg);
    send_byte(8'hA5); send_byte(8'h00);
    txq.delete(); errq.delete();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    repeat (3) @(posedge clk); #1 resetn = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("midrst_no_resp", txq.size(), 0);
    check("midrst_no_err", errq.size(), 0);
    do_frame(8'h08, 8'h00, 8'hAD, 0, 1'b0, rg, eg);
    check("midrst_status", rg, 8'h81);

    // Randomized frames with optional leading noise and response back-pressure.
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb);
      end
      opc = 8'($urandom_range(0, 10));
      arg = (opc == 8'h02) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      chk = opc ^ arg ^ 8'hA5;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      do_frame(opc, arg, chk, $urandom_range(0, 5), 1'b0, rg, eg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
